hazard_unit_mc: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline, extended with multi-cycle EX ops.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_unit_mc_if.sv | 51 +++++
 rtl/hazard_unit_mc_md_stall_ctrl.sv | 56 +++++
 rtl/hazard_unit_mc.sv | 97 +++++++++
 tb/tb_hazard_unit_mc.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the multi-cycle hazard unit.
// Forwarding selects, result/PC source codes and MD FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10,
    FWD_MIMM = 2'b11
  } fwd_sel_t;

  localparam logic [1:0] RESSRC_LOAD = 2'b01;
  localparam logic [1:0] RESSRC_IMM  = 2'b11;
  localparam logic [1:0] PCSRC_NONE  = 2'b00;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave is the hazard unit.
interface hazard_unit_mc_if
  import hazard_pkg::*;
#(
  parameter int RAW   = 5,
  parameter int CNT_W = 16
) ();

  logic             RegWriteM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcE;
  logic [1:0]       ResultSrcM;
  logic [1:0]       PCSrcE;
  logic [RAW-1:0]   Rs1D;
  logic [RAW-1:0]   Rs2D;
  logic             Rs1UsedD;
  logic             Rs2UsedD;
  logic [RAW-1:0]   Rs1E;
  logic [RAW-1:0]   Rs2E;
  logic [RAW-1:0]   RdE;
  logic [RAW-1:0]   RdM;
  logic [RAW-1:0]   RdW;
  logic             MdStartE;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  fwd_sel_t         ForwardAE;
  fwd_sel_t         ForwardBE;
  logic             MdBusy;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE,
           Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, Rs1E, Rs2E, RdE, RdM, RdW, MdStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MdBusy, StallCount, FlushCount
  );

  modport slave (
    input  RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE,
           Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, Rs1E, Rs2E, RdE, RdM, RdW, MdStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MdBusy, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_unit_mc_md_stall_ctrl.sv
// Holds E for a multi-cycle op: stalls cycles t..t+MD_LAT-2, releases at t+MD_LAT-1.
module md_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic md_stall,
  output logic busy
);

  localparam int CW       = $clog2(MD_LAT + 1);
  localparam int LOAD_VAL = (MD_LAT > 1) ? MD_LAT - 2 : 0;

  md_state_t       state_q, state_d;
  logic [CW-1:0]   md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Start is ignored while BUSY so the release cycle cannot retrigger the same op.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start && (MD_LAT > 1)) begin
          state_d  = MD_BUSY;
          md_cnt_d = CW'(LOAD_VAL);
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == '0) state_d = MD_IDLE;
        else                md_cnt_d = md_cnt_q - CW'(1);
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md_stall = 1'b0;
    busy     = (state_q == MD_BUSY);
    if (state_q == MD_IDLE) md_stall = start && (MD_LAT > 1);
    else                    md_stall = (md_cnt_q != '0);
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Forwarding, load-use/redirect/multi-cycle hazard resolution and saturating event counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int RAW     = 5,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16,
  parameter int FWD_IMM = 1
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_mc_if.slave hz
);

  logic             md_stall, md_busy, load_use, redirect;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // M-stage match wins over W-stage so the youngest producer is forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [RAW-1:0] rs, input logic [RAW-1:0] rd_m,
                                       input logic we_m, input logic imm_m,
                                       input logic [RAW-1:0] rd_w, input logic we_w);
    if (rs == '0)                 return FWD_RF;
    else if (rs == rd_m && we_m)  return (imm_m && FWD_IMM != 0) ? FWD_MIMM : FWD_M;
    else if (rs == rd_w && we_w)  return FWD_W;
    else                          return FWD_RF;
  endfunction

  md_stall_ctrl #(.MD_LAT(MD_LAT)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start    (hz.MdStartE),
    .md_stall (md_stall),
    .busy     (md_busy)
  );

  always_comb begin
    load_use = (hz.ResultSrcE == RESSRC_LOAD) && (hz.RdE != '0) &&
               ((hz.Rs1UsedD && hz.Rs1D == hz.RdE) || (hz.Rs2UsedD && hz.Rs2D == hz.RdE));
    redirect = (hz.PCSrcE != PCSRC_NONE);
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (md_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_f && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
    if (flush_d && flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushM     = flush_m;
  assign hz.MdBusy     = md_busy;
  assign hz.StallCount = stall_count_q;
  assign hz.FlushCount = flush_count_q;
  assign hz.ForwardAE  = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.ResultSrcM == RESSRC_IMM,
                                 hz.RdW, hz.RegWriteW);
  assign hz.ForwardBE  = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.ResultSrcM == RESSRC_IMM,
                                 hz.RdW, hz.RegWriteW);

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: forwarding, load-use, redirect, MD stall, reset and counter saturation.
module tb_hazard_unit_mc;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hazard_unit_mc_if #(.RAW(5), .CNT_W(16)) hif  ();
  hazard_unit_mc_if #(.RAW(5), .CNT_W(2))  hif2 ();

  hazard_unit_mc #(.RAW(5), .MD_LAT(4), .CNT_W(16), .FWD_IMM(1)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  hazard_unit_mc #(.RAW(5), .MD_LAT(4), .CNT_W(2), .FWD_IMM(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .hz  (hif2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM}.
  task automatic check_ctrl(input string tag, input logic [5:0] exp);
    check_output(tag, 32'({hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE, hif.FlushM}),
                 32'(exp));
  endtask

  task automatic clear_inputs();
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE = 0; hif.ResultSrcM = 0;
    hif.PCSrcE = 0; hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1UsedD = 0; hif.Rs2UsedD = 0;
    hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0; hif.RdM = 0; hif.RdW = 0; hif.MdStartE = 0;
    hif2.RegWriteM = 0; hif2.RegWriteW = 0; hif2.ResultSrcE = 0; hif2.ResultSrcM = 0;
    hif2.PCSrcE = 0; hif2.Rs1D = 0; hif2.Rs2D = 0; hif2.Rs1UsedD = 0; hif2.Rs2UsedD = 0;
    hif2.Rs1E = 0; hif2.Rs2E = 0; hif2.RdE = 0; hif2.RdM = 0; hif2.RdW = 0; hif2.MdStartE = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    clear_inputs();
    tick();
    tick();

    // Reset state
    check_ctrl("reset_ctrl", 6'b000000);
    check_output("reset_busy", 32'(hif.MdBusy), 32'd0);
    check_output("reset_stallcnt", 32'(hif.StallCount), 32'd0);
    check_output("reset_flushcnt", 32'(hif.FlushCount), 32'd0);
    rst = 1'b1;
    tick();

    // Forwarding
    hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1;
    #1 check_output("fwd_m_alu", 32'(hif.ForwardAE), 32'h2);
    hif.ResultSrcM = 2'b11;
    #1 check_output("fwd_m_imm", 32'(hif.ForwardAE), 32'h3);
    hif.Rs1E = 0;
    #1 check_output("fwd_x0", 32'(hif.ForwardAE), 32'h0);
    hif.Rs1E = 5; hif.RegWriteM = 0; hif.Rs2E = 5;
    #1 check_output("fwd_w_a", 32'(hif.ForwardAE), 32'h1);
    check_output("fwd_w_b", 32'(hif.ForwardBE), 32'h1);
    hif.Rs2E = 9;
    #1 check_output("fwd_none_b", 32'(hif.ForwardBE), 32'h0);
    check_ctrl("fwd_no_hazard", 6'b000000);
    clear_inputs();
    tick();

    // Load-use
    hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7; hif.Rs2UsedD = 1;
    #1 check_ctrl("ld_stall", 6'b110010);
    tick();
    check_output("ld_stallcnt", 32'(hif.StallCount), 32'd1);
    hif.Rs2UsedD = 0;
    #1 check_ctrl("ld_unused", 6'b000000);
    hif.Rs2UsedD = 1; hif.RdE = 0; hif.Rs2D = 0;
    #1 check_ctrl("ld_rd_x0", 6'b000000);
    clear_inputs();
    tick();
    check_output("ld_stallcnt_hold", 32'(hif.StallCount), 32'd1);

    // Redirect over load-use
    hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7; hif.Rs2UsedD = 1; hif.PCSrcE = 2'b10;
    #1 check_ctrl("rd_over_ld", 6'b000110);
    tick();
    clear_inputs();
    #1 check_output("rd_flushcnt", 32'(hif.FlushCount), 32'd1);
    check_output("rd_stallcnt", 32'(hif.StallCount), 32'd1);
    hif.PCSrcE = 2'b01;
    #1 check_ctrl("rd_branch", 6'b000110);
    hif.PCSrcE = 2'b00;
    tick();

    // Multi-cycle op, MD_LAT=4, MdStartE held 4 cycles
    hif.MdStartE = 1;
    #1 check_ctrl("md_t0", 6'b111001);
    check_output("md_t0_busy", 32'(hif.MdBusy), 32'd0);
    tick();
    check_ctrl("md_t1", 6'b111001);
    check_output("md_t1_busy", 32'(hif.MdBusy), 32'd1);
    tick();
    check_ctrl("md_t2", 6'b111001);
    check_output("md_t2_busy", 32'(hif.MdBusy), 32'd1);
    tick();
    check_ctrl("md_release", 6'b000000);
    check_output("md_release_busy", 32'(hif.MdBusy), 32'd1);
    tick();
    hif.MdStartE = 0;
    #1 check_ctrl("md_no_retrigger", 6'b000000);
    check_output("md_done_busy", 32'(hif.MdBusy), 32'd0);
    check_output("md_stallcnt", 32'(hif.StallCount), 32'd4);
    check_output("md_flushcnt", 32'(hif.FlushCount), 32'd1);
    tick();

    // Reset while BUSY
    hif.MdStartE = 1;
    #1 check_ctrl("rst_md_t0", 6'b111001);
    tick();
    check_output("rst_md_busy", 32'(hif.MdBusy), 32'd1);
    rst = 1'b0; hif.MdStartE = 0;
    #1 check_output("rst_busy_drop", 32'(hif.MdBusy), 32'd0);
    check_ctrl("rst_stall_drop", 6'b000000);
    check_output("rst_cnt_clear", 32'(hif.StallCount), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_ctrl("post_rst_idle", 6'b000000);
    check_output("post_rst_busy", 32'(hif.MdBusy), 32'd0);
    check_output("post_rst_cnt", 32'(hif.StallCount), 32'd0);

    // Saturation on the CNT_W=2 instance
    hif2.ResultSrcE = 2'b01; hif2.RdE = 7; hif2.Rs2D = 7; hif2.Rs2UsedD = 1;
    #1 check_output("sat_stallf", 32'(hif2.StallF), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_output($sformatf("sat_cnt_%0d", i), 32'(hif2.StallCount), (i < 3) ? 32'(i) : 32'd3);
    end
    clear_inputs();
    tick();
    check_output("sat_hold", 32'(hif2.StallCount), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
